// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/PC-enable controller for the fetch, decode, exec and mem pipeline latches.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_dreq,
    input  logic [REG_W-1:0]  dec_rs,
    input  logic [REG_W-1:0]  dec_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_memread,
    input  logic              mem_branch_taken,
    input  logic              mem_halt,
    output logic              pc_en,
    output logic              fetch_stall,
    output logic              fetch_flush,
    output logic              dec_stall,
    output logic              dec_flush,
    output logic              exec_stall,
    output logic              exec_flush,
    output logic              mem_stall,
    output logic              mem_flush,
    output logic              halt,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   ihit_seen_q, ihit_seen_d;

    logic active;
    logic dmem_wait;
    logic load_use;
    logic ihit_eff;

    always_comb begin
        active    = (state_q == RUN) || (state_q == DWAIT);
        dmem_wait = active && mem_dreq && !dhit;
        load_use  = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == dec_rs) || (ex_rd == dec_rt));
        // A fetch that completed while the pipe was frozen still counts.
        ihit_eff  = ihit || ihit_seen_q;
    end

    always_comb begin
        pc_en       = 1'b1;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
        dec_stall   = 1'b0;
        dec_flush   = 1'b0;
        exec_stall  = 1'b0;
        exec_flush  = 1'b0;
        mem_stall   = 1'b0;
        mem_flush   = 1'b0;
        halt        = 1'b0;
        state_d     = state_q;
        ihit_seen_d = ihit_seen_q;

        case (state_q)
            HALTED: begin
                halt        = 1'b1;
                pc_en       = 1'b0;
                fetch_stall = 1'b1;
                dec_stall   = 1'b1;
                exec_stall  = 1'b1;
                mem_stall   = 1'b1;
            end
            DRAIN: begin
                // Mem latch advances so the halt instruction reaches writeback.
                pc_en       = 1'b0;
                fetch_flush = 1'b1;
                dec_flush   = 1'b1;
                exec_flush  = 1'b1;
                state_d     = HALTED;
                ihit_seen_d = 1'b0;
            end
            default: begin
                if (dmem_wait) begin
                    pc_en       = 1'b0;
                    fetch_stall = 1'b1;
                    dec_stall   = 1'b1;
                    exec_stall  = 1'b1;
                    mem_stall   = 1'b1;
                    state_d     = DWAIT;
                    ihit_seen_d = ihit_seen_q || ihit;
                end else begin
                    state_d     = RUN;
                    ihit_seen_d = 1'b0;
                    if (mem_halt) begin
                        pc_en       = 1'b0;
                        fetch_flush = 1'b1;
                        dec_flush   = 1'b1;
                        exec_flush  = 1'b1;
                        state_d     = DRAIN;
                    end else if (mem_branch_taken) begin
                        fetch_flush = 1'b1;
                        dec_flush   = 1'b1;
                        exec_flush  = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        fetch_stall = 1'b1;
                        dec_stall   = 1'b1;
                        exec_flush  = 1'b1;
                    end else if (!ihit_eff) begin
                        pc_en       = 1'b0;
                        fetch_flush = 1'b1;
                    end
                end
            end
        endcase

        // Reset is asynchronous, so the outputs must reflect it immediately.
        if (!nRST) begin
            pc_en       = 1'b0;
            fetch_stall = 1'b0;
            dec_stall   = 1'b0;
            exec_stall  = 1'b0;
            mem_stall   = 1'b0;
            fetch_flush = 1'b1;
            dec_flush   = 1'b1;
            exec_flush  = 1'b1;
            mem_flush   = 1'b1;
            halt        = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            ihit_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ihit_seen_q <= ihit_seen_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic              count_stall;
    logic              count_flush;

    always_comb begin
        count_stall = !pc_en && (state_q != HALTED);
        // Only branch and load-use bubbles count; halt-entry flushes do not.
        count_flush = active && !dmem_wait && !mem_halt &&
                      (mem_branch_taken || load_use);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (count_stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
            if (count_flush && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a stage-action reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int PERF_W = 32;
    localparam longint unsigned PERF_MAX = (64'd1 << PERF_W) - 64'd1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              ihit = 1'b0;
    logic              dhit = 1'b0;
    logic              mem_dreq = 1'b0;
    logic [REG_W-1:0]  dec_rs = '0;
    logic [REG_W-1:0]  dec_rt = '0;
    logic [REG_W-1:0]  ex_rd = '0;
    logic              ex_memread = 1'b0;
    logic              mem_branch_taken = 1'b0;
    logic              mem_halt = 1'b0;
    logic              pc_en;
    logic              fetch_stall, fetch_flush;
    logic              dec_stall, dec_flush;
    logic              exec_stall, exec_flush;
    logic              mem_stall, mem_flush;
    logic              halt;
    logic [PERF_W-1:0] perf_stall_cycles;
    logic [PERF_W-1:0] perf_flushes;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .PERF_W(PERF_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
        .pc_en(pc_en),
        .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
        .dec_stall(dec_stall), .dec_flush(dec_flush),
        .exec_stall(exec_stall), .exec_flush(exec_flush),
        .mem_stall(mem_stall), .mem_flush(mem_flush),
        .halt(halt),
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int txn      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // What each pipeline latch does this cycle.
    typedef enum int {ADV, HOLD, BUB} act_e;

    function automatic logic [1:0] sf(input act_e a);
        return {a == HOLD, a == BUB};
    endfunction

    bit              m_halted = 1'b0;
    bit              m_drain  = 1'b0;
    bit              m_seen   = 1'b0;
    longint unsigned m_pstall = 0;
    longint unsigned m_pflush = 0;

    task automatic model_and_check();
        act_e af = ADV, ad = ADV, ae = ADV, am = ADV;
        bit pc = 1'b1, exp_halt = 1'b0, bubble_evt = 1'b0;
        bit was_halted = m_halted;
        bit memwait = mem_dreq && !dhit;
        bit lu = ex_memread && (ex_rd != 0) && ((ex_rd == dec_rs) || (ex_rd == dec_rt));
        bit fetched = ihit || m_seen;
        logic [8:0] exp_ctrl, obs_ctrl;
        longint unsigned exp_ps, exp_pf;

        if (!nRST) begin
            af = BUB; ad = BUB; ae = BUB; am = BUB; pc = 1'b0;
            m_halted = 0; m_drain = 0; m_seen = 0; m_pstall = 0; m_pflush = 0;
            was_halted = 1'b1;
        end else if (m_halted) begin
            af = HOLD; ad = HOLD; ae = HOLD; am = HOLD; pc = 1'b0; exp_halt = 1'b1;
        end else if (m_drain) begin
            af = BUB; ad = BUB; ae = BUB; pc = 1'b0;
            m_drain = 0; m_halted = 1;
        end else if (memwait) begin
            af = HOLD; ad = HOLD; ae = HOLD; am = HOLD; pc = 1'b0;
            if (ihit) m_seen = 1;
        end else begin
            m_seen = 0;
            if (mem_halt) begin
                af = BUB; ad = BUB; ae = BUB; pc = 1'b0; m_drain = 1;
            end else if (mem_branch_taken) begin
                af = BUB; ad = BUB; ae = BUB; bubble_evt = 1'b1;
            end else if (lu) begin
                af = HOLD; ad = HOLD; ae = BUB; pc = 1'b0; bubble_evt = 1'b1;
            end else if (!fetched) begin
                af = BUB; pc = 1'b0;
            end
        end

        exp_ctrl = {pc, sf(af), sf(ad), sf(ae), sf(am)};
        obs_ctrl = {pc_en, fetch_stall, fetch_flush, dec_stall, dec_flush,
                    exec_stall, exec_flush, mem_stall, mem_flush};
`ifdef HAZARD_PERF_CNT_EN
        exp_ps = m_pstall;
        exp_pf = m_pflush;
`else
        exp_ps = 0;
        exp_pf = 0;
`endif
        check_eq($sformatf("ctrl@%0d", txn), 32'(obs_ctrl), 32'(exp_ctrl));
        check_eq($sformatf("halt@%0d", txn), 32'(halt), 32'(exp_halt));
        check_eq($sformatf("perf_stall@%0d", txn), 32'(perf_stall_cycles), 32'(exp_ps));
        check_eq($sformatf("perf_flush@%0d", txn), 32'(perf_flushes), 32'(exp_pf));
        $display("txn %0d rst_n=%0b ctrl=%b halt=%0b", txn, nRST, obs_ctrl, halt);

        if (nRST) begin
            if (!pc && !was_halted && m_pstall != PERF_MAX) m_pstall++;
            if (bubble_evt && m_pflush != PERF_MAX) m_pflush++;
        end
        txn++;
    endtask

    task automatic cyc(input bit rst_n, input bit ih, input bit dh, input bit dq,
                       input int rs, input int rt, input int rd,
                       input bit mr, input bit br, input bit mh);
        @(negedge CLK);
        nRST = rst_n; ihit = ih; dhit = dh; mem_dreq = dq;
        dec_rs = rs[REG_W-1:0]; dec_rt = rt[REG_W-1:0]; ex_rd = rd[REG_W-1:0];
        ex_memread = mr; mem_branch_taken = br; mem_halt = mh;
        #1;
        model_and_check();
    endtask

    initial begin
        // Reset, then normal flow
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Data-memory wait with an ihit pulse mid-stall, then dhit with ihit low
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rt, then ex_rd=0 never stalls
        cyc(1, 1, 0, 0, 3, 8, 8, 1, 0, 0);
        cyc(1, 1, 0, 0, 3, 5, 4, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
        // Branch beats load-use and fetch wait
        cyc(1, 0, 0, 0, 9, 2, 9, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Halt deferred by data wait, then drain, then sticky halt
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional resets and halts
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 49) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 19) < 3,
                $urandom_range(0, 29) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
